// File: rtl/button_event_decoder_pkg.sv
// rtl/button_event_decoder_pkg.sv - shared state and event encodings for the button event decoder
package button_event_decoder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT_GAP,
    PRESS2,
    LONG_HOLD
  } state_t;

  // Compact event code so downstream logic can mux one event field instead of four pulses
  typedef enum logic [1:0] {
    CLICK = 2'd0,
    DBL   = 2'd1,
    LONG  = 2'd2,
    RPT   = 2'd3
  } event_t;

endpackage

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - classifies a debounced button level into click/double/long/repeat pulses
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int LONG_CYCLES   = 50000000,
  parameter int GAP_CYCLES    = 15000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  output logic click,
  output logic dbl_click,
  output logic long_press,
  output logic repeat_tick,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_TC  = CNT_W'(REPEAT_CYCLES - 1);

  localparam bit PARAMS_OK = (LONG_CYCLES >= 2) && (GAP_CYCLES >= 2) && (REPEAT_CYCLES >= 2)
                          && ((64'(LONG_CYCLES) >> CNT_W) == 64'd0)
                          && ((64'(GAP_CYCLES) >> CNT_W) == 64'd0)
                          && ((64'(REPEAT_CYCLES) >> CNT_W) == 64'd0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ev_vld;
  event_t           ev_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      click       <= 1'b0;
      dbl_click   <= 1'b0;
      long_press  <= 1'b0;
      repeat_tick <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      click       <= ev_vld && (ev_code == CLICK);
      dbl_click   <= ev_vld && (ev_code == DBL);
      long_press  <= ev_vld && (ev_code == LONG);
      repeat_tick <= ev_vld && (ev_code == RPT);
      busy        <= (state_nxt != IDLE);
    end
  end

  // Every state exits or reloads at its terminal count, so cnt never wraps
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ev_vld    = 1'b0;
    ev_code   = CLICK;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (btn_level) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (!btn_level) begin
          state_nxt = WAIT_GAP;
          cnt_nxt   = '0;
        end else if (cnt == LONG_TC) begin
          state_nxt = LONG_HOLD;
          cnt_nxt   = '0;
          ev_vld    = 1'b1;
          ev_code   = LONG;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      LONG_HOLD: begin
        if (!btn_level) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == RPT_TC) begin
          cnt_nxt = '0;
          ev_vld  = 1'b1;
          ev_code = RPT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_GAP: begin
        // A press on the timeout edge still becomes the second press
        if (btn_level) begin
          state_nxt = PRESS2;
          cnt_nxt   = '0;
        end else if (cnt == GAP_TC) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          ev_vld    = 1'b1;
          ev_code   = CLICK;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESS2: begin
        cnt_nxt = '0;
        if (!btn_level) begin
          state_nxt = IDLE;
          ev_vld    = 1'b1;
          ev_code   = DBL;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  param_legal: assert property (@(posedge clk) PARAMS_OK);

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - randomized self-checking bench for button_event_decoder
module tb_button_event_decoder;

  localparam int LONG = 20;
  localparam int GAP  = 8;
  localparam int REP  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_level = 1'b0;
  logic click, dbl_click, long_press, repeat_tick, busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: press/release timestamps measured in sampled edges
  int   cyc = 0;
  int   phase = 0;  // 0 none, 1 first held, 2 released, 3 second held, 4 long held
  int   t_press, t_rel, t_long;
  logic [4:0] exp_vec = '0;
  logic [4:0] obs;

  assign obs = {click, dbl_click, long_press, repeat_tick, busy};

  button_event_decoder #(
    .CNT_W(32), .LONG_CYCLES(LONG), .GAP_CYCLES(GAP), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_level),
    .click(click), .dbl_click(dbl_click), .long_press(long_press),
    .repeat_tick(repeat_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_step(input logic b);
    logic c = 1'b0, d = 1'b0, l = 1'b0, r = 1'b0;
    cyc++;
    case (phase)
      0: if (b) begin phase = 1; t_press = cyc; end
      1: if (!b) begin phase = 2; t_rel = cyc; end
         else if (cyc - t_press == LONG) begin l = 1'b1; phase = 4; t_long = cyc; end
      4: if (!b) phase = 0;
         else if ((cyc - t_long) % REP == 0) r = 1'b1;
      2: if (b) phase = 3;
         else if (cyc - t_rel == GAP) begin c = 1'b1; phase = 0; end
      3: if (!b) begin d = 1'b1; phase = 0; end
      default: phase = 0;
    endcase
    exp_vec = {c, d, l, r, phase != 0};
  endtask

  task automatic model_reset();
    phase = 0;
    exp_vec = '0;
  endtask

  // Drive one level at the negedge, let the DUT and model take the posedge, return at the next negedge
  task automatic drive(input logic b);
    btn_level = b;
    @(posedge clk);
    model_step(b);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if (obs !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_state got=%b exp=%b", obs, 5'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0);
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL reset_idle i=%0d got=%b exp=%b", i, obs, exp_vec);
      end
    end
  endtask

  task automatic test_single_click();
    int click_idx = -1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1);
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL click_press i=%0d got=%b exp=%b", i, obs, exp_vec);
      end
    end
    for (int i = 1; i <= 12; i++) begin
      drive(1'b0);
      if (click) click_idx = i;
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL click_release i=%0d got=%b exp=%b", i, obs, exp_vec);
      end
    end
    vectors++;
    if (click_idx !== 9) begin
      miscompares++;
      $display("FAIL click_latency got=%0d exp=%0d", click_idx, 9);
    end
  endtask

  task automatic test_double_click();
    logic lv[$] = '{1,1,1,0,0,0,1,1,1,0,0,0,0,0,0,0,0,0,0,0};
    int dbl_cnt = 0, clk_cnt = 0;
    foreach (lv[i]) begin
      drive(lv[i]);
      dbl_cnt += dbl_click;
      clk_cnt += click;
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL double i=%0d got=%b exp=%b", i, obs, exp_vec);
      end
    end
    vectors++;
    if (dbl_cnt != 1 || clk_cnt != 0) begin
      miscompares++;
      $display("FAIL double_count got=%0d/%0d exp=1/0", dbl_cnt, clk_cnt);
    end
  endtask

  task automatic test_long_repeat();
    int long_idx = -1, rpt_cnt = 0, ev_cnt = 0;
    for (int i = 1; i <= 46; i++) begin
      drive(i <= 36);
      if (long_press) long_idx = i;
      rpt_cnt += repeat_tick;
      if (i > 36) ev_cnt += click + dbl_click + long_press + repeat_tick;
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL long i=%0d got=%b exp=%b", i, obs, exp_vec);
      end
    end
    vectors++;
    if (long_idx != 21 || rpt_cnt != 3 || ev_cnt != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL long_summary got=idx%0d rpt%0d post%0d busy%b exp=idx21 rpt3 post0 busy0",
               long_idx, rpt_cnt, ev_cnt, busy);
    end
  endtask

  task automatic test_gap_boundary();
    // 3 press, 8 low (second press lands on the timeout edge), then 9 low (one later)
    for (int pass = 0; pass < 2; pass++) begin
      int clk_cnt = 0, dbl_cnt = 0;
      logic lv[$] = '{1,1,1};
      for (int i = 0; i < 8 + pass; i++) lv.push_back(1'b0);
      lv.push_back(1'b1); lv.push_back(1'b1); lv.push_back(1'b1);
      for (int i = 0; i < 12; i++) lv.push_back(1'b0);
      foreach (lv[i]) begin
        drive(lv[i]);
        clk_cnt += click;
        dbl_cnt += dbl_click;
        vectors++;
        if (obs !== exp_vec) begin
          miscompares++;
          $display("FAIL gap_p%0d i=%0d got=%b exp=%b", pass, i, obs, exp_vec);
        end
      end
      vectors++;
      if (clk_cnt != 2 * pass || dbl_cnt != 1 - pass) begin
        miscompares++;
        $display("FAIL gap_count_p%0d got=c%0d d%0d exp=c%0d d%0d",
                 pass, clk_cnt, dbl_cnt, 2 * pass, 1 - pass);
      end
    end
  endtask

  task automatic test_reset_gap();
    for (int i = 0; i < 3; i++) drive(1'b1);
    drive(1'b0);
    drive(1'b0);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_gap_busy_before got=%b exp=1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (obs !== 5'b0) begin
      miscompares++;
      $display("FAIL rst_gap_async got=%b exp=%b", obs, 5'b0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(1'b0);
      vectors++;
      if (obs !== 5'b0 || exp_vec !== 5'b0) begin
        miscompares++;
        $display("FAIL rst_gap_quiet i=%0d got=%b exp=%b", i, obs, 5'b0);
      end
    end
  endtask

  task automatic test_reset_hold();
    int long_idx = -1;
    for (int i = 0; i < 25; i++) drive(1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (obs !== 5'b0) begin
      miscompares++;
      $display("FAIL rst_hold_async got=%b exp=%b", obs, 5'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 23; i++) begin
      drive(1'b1);
      if (long_press) long_idx = i;
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL rst_hold i=%0d got=%b exp=%b", i, obs, exp_vec);
      end
    end
    vectors++;
    if (long_idx != 21) begin
      miscompares++;
      $display("FAIL rst_hold_long_idx got=%0d exp=21", long_idx);
    end
    for (int i = 0; i < 12; i++) drive(1'b0);
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 250; seg++) begin
      int hi = $urandom_range(1, 28);
      int lo = ($urandom_range(0, 3) == 0) ? $urandom_range(7, 10) : $urandom_range(1, 12);
      for (int i = 0; i < hi + lo; i++) begin
        drive(i < hi);
        vectors++;
        if (obs !== exp_vec) begin
          miscompares++;
          $display("FAIL random seg=%0d i=%0d got=%b exp=%b", seg, i, obs, exp_vec);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_click();
    test_double_click();
    test_long_repeat();
    test_gap_boundary();
    test_reset_gap();
    test_reset_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
